vpu_wb_sequencer: RTL
=====================

Name: vpu_wb_sequencer

Overview:
Sequences one vector writeback operation from the VPU lanes into the destination SRAM write port. It latches a destination base address and beat count from the VPU controller, then buffers lane result beats in a small FIFO. It issues one SRAM write per beat at incrementing addresses and reports completion back to the controller. It sits between the lane writeback outputs and the destination SRAM, inside the destination-port path.

Parameters:
OPERAND_WIDTH, 32, bits per lane operand
VLANE_CNT, 8, number of vector lanes; beat width = OPERAND_WIDTH*VLANE_CNT
SRAM_ADDR_WIDTH, 10, SRAM word-address width
LEN_WIDTH, 8, width of the beat-count field
FIFO_DEPTH, 4, writeback buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  controller start pulse; sampled only in IDLE
dst_addr_i  in  SRAM_ADDR_WIDTH  destination base address, latched on start
beat_cnt_i  in  LEN_WIDTH  number of beats to write, latched on start
reset_cmd_i  in  1  controller abort/acknowledge; returns block to IDLE
busy_o  out  1  high in RUN
done_o  out  1  high in DONE, held until reset_cmd_i
err_o  out  1  sticky: wb beat arrived while wb_ready_o=0
wb_data_wren_i  in  1  lane beat valid
wb_data_i  in  OPERAND_WIDTH*VLANE_CNT  lane beat data
wb_ready_o  out  1  sequencer can accept a beat this cycle
sram_wren_o  out  1  SRAM write request
sram_waddr_o  out  SRAM_ADDR_WIDTH  SRAM write address
sram_wdata_o  out  OPERAND_WIDTH*VLANE_CNT  SRAM write data
sram_wready_i  in  1  SRAM accepts the write this cycle

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low, applied on the clk edge.
- Reset state:
  - FSM is in IDLE.
  - All counters, the FIFO and err_o are cleared.
  - Every output is 0, including sram_waddr_o and sram_wdata_o.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start_i, latch base_addr and total, and clear acc_cnt and wr_cnt.
  - If beat_cnt_i==0, go directly to DONE. Otherwise go to RUN.
- RUN:
  - wb_ready_o = !fifo_full && (acc_cnt != total).
  - A beat is accepted when wb_data_wren_i && wb_ready_o: push to FIFO and increment acc_cnt.
  - SRAM side: sram_wren_o = !fifo_empty, sram_wdata_o = FIFO head, sram_waddr_o = base_addr + wr_cnt (modulo 2^SRAM_ADDR_WIDTH, wraps silently).
  - A write completes when sram_wren_o && sram_wready_i: pop the FIFO and increment wr_cnt.
  - sram_wren_o, address and data stay stable while sram_wready_i=0.
  - When the completing write makes wr_cnt==total, go to DONE on the next edge.
- DONE:
  - done_o=1, busy_o=0, wb_ready_o=0, sram_wren_o=0.
  - Stay in DONE until reset_cmd_i, then go to IDLE.
  - start_i is ignored in DONE.
- reset_cmd_i in any state:
  - Next state is IDLE; flush the FIFO and clear counters and err_o.
  - Any beats still in flight are discarded (abort).
  - reset_cmd_i has priority over start_i in the same cycle.
- start_i outside IDLE is ignored.
- A beat arriving while wb_ready_o=0 (including in IDLE and DONE) is dropped and sets err_o. err_o is sticky until reset_cmd_i or rst_n.
- Latency: a beat accepted at edge t drives sram_wren_o from cycle t+1. With sram_wready_i tied high, throughput is one beat per cycle.
- FIFO full: a simultaneous push and pop is not allowed; wb_ready_o is low whenever the FIFO is full.
- FIFO empty with a push: the data becomes visible on the following cycle (no bypass path).
- Count fields are LEN_WIDTH bits. The maximum transfer is 2^LEN_WIDTH-1 beats.

Decomposition:
- VPU_PKG holds:
  - OPERAND_WIDTH, VLANE_CNT, SRAM_ADDR_WIDTH and LEN_WIDTH defaults;
  - the wb_seq_state_t enum (IDLE, RUN, DONE);
  - the beat-width localparam.
- One sub-module, vpu_wb_fifo: a synchronous FIFO with parameters DEPTH and WIDTH, ports push/pop/full/empty/rdata, and a synchronous flush input.

Test Plan:
1. start, addr=0x010, cnt=4, sram_wready_i=1, 4 back-to-back beats D0..D3 -> writes to 0x010..0x013 on consecutive cycles, first write one cycle after D0; done_o rises after D3 is written; busy_o falls.
2. addr=0x3FE, cnt=4 -> write addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap), data in order.
3. cnt=8, sram_wready_i=0 for 10 cycles, lanes push continuously -> exactly 4 beats accepted, then wb_ready_o=0. sram_wren_o holds on 0x base with stable data. After release, all 8 are written in order and done_o asserts.
4. cnt=0 start -> DONE next cycle with zero SRAM writes. reset_cmd_i -> IDLE, done_o=0.
5. Abort: cnt=6, reset_cmd_i after 2 writes with 2 beats buffered -> next cycle IDLE, FIFO empty, sram_wren_o=0. A new start with addr=0x020, cnt=1 writes only the new beat at 0x020.
6. wb_data_wren_i in IDLE, and a 5th beat when cnt=4 -> the beat is dropped and err_o=1 (sticky). The SRAM write count stays unchanged. reset_cmd_i clears err_o.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared defaults and types for the VPU destination-port writeback path.
package vpu_pkg;

    localparam int unsigned DEF_OPERAND_WIDTH   = 32;
    localparam int unsigned DEF_VLANE_CNT       = 8;
    localparam int unsigned DEF_SRAM_ADDR_WIDTH = 10;
    localparam int unsigned DEF_LEN_WIDTH       = 8;
    localparam int unsigned DEF_FIFO_DEPTH      = 4;
    localparam int unsigned DEF_BEAT_WIDTH      = DEF_OPERAND_WIDTH * DEF_VLANE_CNT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_seq_state_t;

endpackage

// File: rtl/vpu_wb_fifo.sv
// Small synchronous FIFO buffering lane beats ahead of the SRAM write port; no bypass.
module vpu_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/vpu_wb_sequencer.sv
// Sequences one vector writeback: buffers lane beats and writes them to SRAM
// at incrementing addresses from a latched base, then reports completion.
module vpu_wb_sequencer
    import vpu_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH   = DEF_OPERAND_WIDTH,
    parameter int unsigned VLANE_CNT       = DEF_VLANE_CNT,
    parameter int unsigned SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH       = DEF_LEN_WIDTH,
    parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic [SRAM_ADDR_WIDTH-1:0]         dst_addr_i,
    input  logic [LEN_WIDTH-1:0]               beat_cnt_i,
    input  logic                               reset_cmd_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    input  logic                               wb_data_wren_i,
    input  logic [OPERAND_WIDTH*VLANE_CNT-1:0] wb_data_i,
    output logic                               wb_ready_o,
    output logic                               sram_wren_o,
    output logic [SRAM_ADDR_WIDTH-1:0]         sram_waddr_o,
    output logic [OPERAND_WIDTH*VLANE_CNT-1:0] sram_wdata_o,
    input  logic                               sram_wready_i
);

    localparam int unsigned BEAT_WIDTH = OPERAND_WIDTH * VLANE_CNT;

    wb_seq_state_t              state_q;
    wb_seq_state_t              state_d;
    logic [SRAM_ADDR_WIDTH-1:0] base_addr_q;
    logic [LEN_WIDTH-1:0]       total_q;
    logic [LEN_WIDTH-1:0]       acc_cnt_q;
    logic [LEN_WIDTH-1:0]       wr_cnt_q;
    logic                       err_q;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [BEAT_WIDTH-1:0]      fifo_rdata;
    logic                       push;
    logic                       pop;

    // Every output below is a function of registered state only.
    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign wb_ready_o   = (state_q == RUN) && !fifo_full && (acc_cnt_q != total_q);
    assign sram_wren_o  = (state_q == RUN) && !fifo_empty;
    assign sram_waddr_o = base_addr_q + SRAM_ADDR_WIDTH'(wr_cnt_q);
    assign sram_wdata_o = sram_wren_o ? fifo_rdata : '0;

    assign push = wb_data_wren_i && wb_ready_o;
    assign pop  = sram_wren_o && sram_wready_i;

    vpu_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (reset_cmd_i),
        .push  (push),
        .wdata (wb_data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic; the controller's reset command overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (beat_cnt_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && ((wr_cnt_q + LEN_WIDTH'(1)) == total_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (reset_cmd_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_addr_q <= '0;
            total_q     <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (reset_cmd_i) begin
                total_q   <= '0;
                acc_cnt_q <= '0;
                wr_cnt_q  <= '0;
                err_q     <= 1'b0;
            end else begin
                if ((state_q == IDLE) && start_i) begin
                    base_addr_q <= dst_addr_i;
                    total_q     <= beat_cnt_i;
                    acc_cnt_q   <= '0;
                    wr_cnt_q    <= '0;
                end
                if (push) begin
                    acc_cnt_q <= acc_cnt_q + LEN_WIDTH'(1);
                end
                if (pop) begin
                    wr_cnt_q <= wr_cnt_q + LEN_WIDTH'(1);
                end
                if (wb_data_wren_i && !wb_ready_o) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule
